serial_alu: RTL and testbench

- Parametrised digit-serial successor to the 1-bit conditional inverter/ALU slice.
- Processes WIDTH-bit operands DIGIT bits per cycle, LSB digit first.
- Applies per-operand conditional inversion (ainvert/binvert) and AND/OR/ADD/SLT per digit, rippling carry through a register between cycles.
- Sits between the decode stage and the register-file write path; valid/ready handshakes on both sides.

---
 rtl/alu_defs.sv | 27 ++
 rtl/invert_vec.sv | 16 +
 rtl/serial_alu.sv | 173 +++++++++++++++++
 tb/tb_serial_alu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the digit-serial ALU.
// Holds the op codes, the complete ctrl words for the common operations and
// the controller state encoding.
package alu_defs;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } op_e;

    // ctrl = {ainvert, binvert, op[1:0]}
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/invert_vec.sv
// Conditional vector inverter: out_o = in_i ^ {W{inv_i}}.
// Ports:
//   in_i   [W-1:0]  input vector
//   inv_i           invert enable
//   out_o  [W-1:0]  conditionally inverted vector
module invert_vec #(
    parameter int W = 4
) (
    input  logic [W-1:0] in_i,
    input  logic         inv_i,
    output logic [W-1:0] out_o
);

    assign out_o = in_i ^ {W{inv_i}};

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU. Processes WIDTH-bit operands DIGIT bits per cycle, LSB
// digit first, with per-operand conditional inversion and AND/OR/ADD/SLT.
// The carry ripples between digits through a register.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   in_valid_i / in_ready_o  operand handshake
//   src1_i, src2_i, ctrl_i   operands and {ainvert, binvert, op[1:0]}
//   out_valid_o / out_ready_i result handshake
//   result_o, zero_o, cout_o, overflow_o  result and flags
//
// state | meaning
// IDLE  | ready for a new operation
// RUN   | one digit processed per clock
// DONE  | result valid, held until the consumer accepts it
module serial_alu
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] a_dig, b_dig, a_inv, b_inv, dig_res;
    logic [DIGIT:0]   sum_ext;
    logic             c_msb, ovf_dig, is_arith;
    op_e              op;

    assign a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];

    invert_vec #(.W(DIGIT)) u_inv_a (
        .in_i  (a_dig),
        .inv_i (ctrl_q[3]),
        .out_o (a_inv)
    );

    invert_vec #(.W(DIGIT)) u_inv_b (
        .in_i  (b_dig),
        .inv_i (ctrl_q[2]),
        .out_o (b_inv)
    );

    assign op       = op_e'(ctrl_q[1:0]);
    assign is_arith = ctrl_q[1];
    assign sum_ext  = {1'b0, a_inv} + {1'b0, b_inv} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the digit MSB recovered from the MSB sum bit; only meaningful
    // on the final digit, where it is the carry into bit WIDTH-1.
    assign c_msb    = a_inv[DIGIT-1] ^ b_inv[DIGIT-1] ^ sum_ext[DIGIT-1];
    assign ovf_dig  = c_msb ^ sum_ext[DIGIT];

    always_comb begin
        case (op)
            OP_AND:  dig_res = a_inv & b_inv;
            OP_OR:   dig_res = a_inv | b_inv;
            default: dig_res = sum_ext[DIGIT-1:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = src1_i;
                    b_d     = src2_i;
                    ctrl_d  = ctrl_i;
                    carry_d = ctrl_i[2];
                    cnt_d   = '0;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_res;
                if (is_arith) begin
                    carry_d = sum_ext[DIGIT];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (is_arith) begin
                        cout_d = sum_ext[DIGIT];
                        ovf_d  = ovf_dig;
                    end
                    if (op == OP_SLT) begin
                        res_d = WIDTH'(sum_ext[DIGIT-1] ^ ovf_dig);
                    end
                    zero_d = ~|res_d;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = res_q;
    assign zero_o      = zero_q;
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
module tb_serial_alu;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: WIDTH=32, DIGIT=4
    logic        m_in_valid = 0, m_in_ready, m_out_valid, m_out_ready = 0;
    logic [31:0] m_src1 = 0, m_src2 = 0, m_result;
    logic [3:0]  m_ctrl = 0;
    logic        m_zero, m_cout, m_ovf;

    // single-cycle instance: WIDTH=32, DIGIT=32
    logic        w_in_valid = 0, w_in_ready, w_out_valid, w_out_ready = 0;
    logic [31:0] w_src1 = 0, w_src2 = 0, w_result;
    logic [3:0]  w_ctrl = 0;
    logic        w_zero, w_cout, w_ovf;

    // bit-serial instance: WIDTH=8, DIGIT=1
    logic        s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0;
    logic [7:0]  s_src1 = 0, s_src2 = 0, s_result;
    logic [3:0]  s_ctrl = 0;
    logic        s_zero, s_cout, s_ovf;

    serial_alu #(.WIDTH(32), .DIGIT(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(m_in_valid), .in_ready_o(m_in_ready),
        .src1_i(m_src1), .src2_i(m_src2), .ctrl_i(m_ctrl), .out_valid_o(m_out_valid),
        .out_ready_i(m_out_ready), .result_o(m_result), .zero_o(m_zero),
        .cout_o(m_cout), .overflow_o(m_ovf)
    );

    serial_alu #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
        .src1_i(w_src1), .src2_i(w_src2), .ctrl_i(w_ctrl), .out_valid_o(w_out_valid),
        .out_ready_i(w_out_ready), .result_o(w_result), .zero_o(w_zero),
        .cout_o(w_cout), .overflow_o(w_ovf)
    );

    serial_alu #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .src1_i(s_src1), .src2_i(s_src2), .ctrl_i(s_ctrl), .out_valid_o(s_out_valid),
        .out_ready_i(s_out_ready), .result_o(s_result), .zero_o(s_zero),
        .cout_o(s_cout), .overflow_o(s_ovf)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb_q[$];
    exp_t last_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Whole-word reference for a 32-bit operation.
    function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        exp_t        e;
        logic [31:0] ap, bp;
        logic [32:0] s;
        logic        ovf;
        ap  = c[3] ? ~a : a;
        bp  = c[2] ? ~b : b;
        s   = {1'b0, ap} + {1'b0, bp} + {32'd0, c[2]};
        ovf = (ap[31] == bp[31]) && (s[31] != ap[31]);
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        case (c[1:0])
            2'b00: e.res = ap & bp;
            2'b01: e.res = ap | bp;
            2'b10: e.res = s[31:0];
            default: e.res = {31'd0, s[31] ^ ovf};
        endcase
        if (c[1]) begin
            e.cout = s[32];
            e.ovf  = ovf;
        end
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Issue one op to the main instance and compare its result; leaves it in DONE.
    task automatic m_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        int   cyc;
        exp_t e;
        check("m_in_ready_before_issue", {31'd0, m_in_ready}, 32'd1);
        m_src1 = a; m_src2 = b; m_ctrl = c; m_in_valid = 1'b1;
        sb_q.push_back(model32(a, b, c));
        @(negedge clk);
        m_in_valid = 1'b0;
        cyc = 0;
        while (!m_out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("m_latency", cyc, 32'd8);
        check("m_in_ready_in_done", {31'd0, m_in_ready}, 32'd0);
        e = sb_q.pop_front();
        last_exp = e;
        check("m_result", m_result, e.res);
        check("m_zero", {31'd0, m_zero}, {31'd0, e.zero});
        check("m_cout", {31'd0, m_cout}, {31'd0, e.cout});
        check("m_overflow", {31'd0, m_ovf}, {31'd0, e.ovf});
    endtask

    task automatic m_release();
        m_out_ready = 1'b1;
        @(negedge clk);
        m_out_ready = 1'b0;
        check("m_out_valid_after_accept", {31'd0, m_out_valid}, 32'd0);
        check("m_in_ready_after_accept", {31'd0, m_in_ready}, 32'd1);
    endtask

    initial begin
        int   cyc;
        logic seen;
        exp_t e;

        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, m_in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
        check("rst_result", m_result, 32'd0);
        check("rst_zero", {31'd0, m_zero}, 32'd0);
        check("rst_cout", {31'd0, m_cout}, 32'd0);
        check("rst_overflow", {31'd0, m_ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD with signed overflow
        m_run(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        check("add_ovf_result", m_result, 32'h8000_0000);
        m_release();
        // SUB to zero
        m_run(32'd5, 32'd5, 4'b0110);
        check("sub_zero_flag", {31'd0, m_zero}, 32'd1);
        m_release();
        // SLT -1 < 1
        m_run(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111);
        check("slt_result", m_result, 32'h0000_0001);
        m_release();
        // NOR
        m_run(32'h0F0F_0F0F, 32'hF0F0_0000, 4'b1100);
        check("nor_result", m_result, 32'h0000_F0F0);
        m_release();
        // AND, OR, SLT false, a-inverted add on pseudo-random operands
        m_run($urandom, $urandom, 4'b0000); m_release();
        m_run($urandom, $urandom, 4'b0001); m_release();
        m_run(32'd3, 32'd9, 4'b0111);      m_release();
        m_run(32'd9, 32'd3, 4'b0111);      m_release();
        m_run($urandom, $urandom, 4'b1010); m_release();

        // back-pressure with in_valid pulsing new operands in DONE
        m_run(32'h1234_5678, 32'h1111_1111, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            m_src1 = $urandom; m_src2 = $urandom; m_ctrl = 4'b0001;
            m_in_valid = (i != 1);
            @(negedge clk);
            check("bp_out_valid", {31'd0, m_out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, m_in_ready}, 32'd0);
            check("bp_result_hold", m_result, last_exp.res);
        end
        m_in_valid = 1'b0;
        m_release();
        m_run(32'hCAFE_0000, 32'h0000_BEEF, 4'b0001);
        check("bp_new_op", m_result, 32'hCAFE_BEEF);
        m_release();

        // reset during the 4th RUN cycle
        m_src1 = 32'hFFFF_FFFF; m_src2 = 32'h1; m_ctrl = 4'b0010; m_in_valid = 1'b1;
        @(negedge clk);
        m_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", {31'd0, m_in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, m_out_valid}, 32'd0);
        check("abort_result", m_result, 32'd0);
        check("abort_flags", {29'd0, m_zero, m_cout, m_ovf}, 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", {31'd0, seen}, 32'd0);

        // DIGIT == WIDTH: single-cycle latency
        w_src1 = 32'hFFFF_FFFF; w_src2 = 32'h1; w_ctrl = 4'b0010; w_in_valid = 1'b1;
        sb_q.push_back(model32(32'hFFFF_FFFF, 32'h1, 4'b0010));
        @(negedge clk);
        w_in_valid = 1'b0;
        cyc = 0;
        while (!w_out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        check("d32_latency", cyc, 32'd1);
        check("d32_result", w_result, e.res);
        check("d32_cout", {31'd0, w_cout}, {31'd0, e.cout});
        check("d32_zero", {31'd0, w_zero}, {31'd0, e.zero});
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        check("d32_release", {31'd0, w_in_ready}, 32'd1);

        // WIDTH=8 DIGIT=1: 0xFF + 0x01 wraps to zero with carry out
        s_src1 = 8'hFF; s_src2 = 8'h01; s_ctrl = 4'b0010; s_in_valid = 1'b1;
        e.res = 32'd0; e.zero = 1'b1; e.cout = 1'b1; e.ovf = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        s_in_valid = 1'b0;
        cyc = 0;
        while (!s_out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        check("d1_latency", cyc, 32'd8);
        check("d1_result", {24'd0, s_result}, e.res);
        check("d1_cout", {31'd0, s_cout}, {31'd0, e.cout});
        check("d1_zero", {31'd0, s_zero}, {31'd0, e.zero});
        check("d1_overflow", {31'd0, s_ovf}, {31'd0, e.ovf});
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
